// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the instruction/data memory arbiter.
// State and owner encodings are visible to any stage that decodes them.
package mem_arbiter_pkg;

   localparam int unsigned BE_WIDTH = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } arb_state_e;

   typedef enum logic {
      OWN_DATA = 1'b0,
      OWN_INST = 1'b1
   } owner_e;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates the fetch and MEM-stage ports onto one shared bus, one transaction at a time.
// The data port wins ties; completion is a registered one-cycle done pulse with read data.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  inst_en,
   input  logic [ADDR_WIDTH-1:0] inst_addr,
   output logic [DATA_WIDTH-1:0] inst_rdata,
   output logic                  inst_done,
   input  logic                  data_en,
   input  logic [BE_WIDTH-1:0]   data_write_en,
   input  logic [ADDR_WIDTH-1:0] data_addr,
   input  logic [DATA_WIDTH-1:0] data_write_data,
   output logic [DATA_WIDTH-1:0] data_rdata,
   output logic                  data_done,
   output logic                  stall_req,
   output logic                  bus_req,
   output logic [BE_WIDTH-1:0]   bus_we,
   output logic [ADDR_WIDTH-1:0] bus_addr,
   output logic [DATA_WIDTH-1:0] bus_wdata,
   input  logic                  bus_addr_ok,
   input  logic                  bus_data_ok,
   input  logic [DATA_WIDTH-1:0] bus_rdata
);

   arb_state_e            state_q, state_d;
   owner_e                owner_q, owner_d;
   logic                  bus_req_d;
   logic [BE_WIDTH-1:0]   bus_we_d;
   logic [ADDR_WIDTH-1:0] bus_addr_d;
   logic [DATA_WIDTH-1:0] bus_wdata_d;
   logic                  inst_done_d, data_done_d;
   logic [DATA_WIDTH-1:0] inst_rdata_d, data_rdata_d;
   logic                  complete;

   // A port stays in stall until its done pulse is seen
   assign stall_req = (data_en & ~data_done) | (inst_en & ~inst_done);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         owner_q    <= OWN_DATA;
         bus_req    <= 1'b0;
         bus_we     <= '0;
         bus_addr   <= '0;
         bus_wdata  <= '0;
         inst_done  <= 1'b0;
         data_done  <= 1'b0;
         inst_rdata <= '0;
         data_rdata <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         bus_req    <= bus_req_d;
         bus_we     <= bus_we_d;
         bus_addr   <= bus_addr_d;
         bus_wdata  <= bus_wdata_d;
         inst_done  <= inst_done_d;
         data_done  <= data_done_d;
         inst_rdata <= inst_rdata_d;
         data_rdata <= data_rdata_d;
      end
   end

   // Next state, bus request payload and completion
   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      bus_req_d    = bus_req;
      bus_we_d     = bus_we;
      bus_addr_d   = bus_addr;
      bus_wdata_d  = bus_wdata;
      inst_done_d  = 1'b0;
      data_done_d  = 1'b0;
      inst_rdata_d = inst_rdata;
      data_rdata_d = data_rdata;
      complete     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // done=1 masks the port so a held enable is not re-granted in its done cycle
            if (data_en && !data_done) begin
               state_d     = ST_REQ;
               owner_d     = OWN_DATA;
               bus_req_d   = 1'b1;
               bus_we_d    = data_write_en;
               bus_addr_d  = data_addr;
               bus_wdata_d = data_write_data;
            end else if (inst_en && !inst_done) begin
               state_d     = ST_REQ;
               owner_d     = OWN_INST;
               bus_req_d   = 1'b1;
               bus_we_d    = '0;
               bus_addr_d  = inst_addr;
               bus_wdata_d = '0;
            end
         end
         ST_REQ: begin
            if (bus_addr_ok) begin
               bus_req_d   = 1'b0;
               bus_we_d    = '0;
               bus_addr_d  = '0;
               bus_wdata_d = '0;
               if (bus_data_ok) begin
                  state_d  = ST_IDLE;
                  complete = 1'b1;
               end else begin
                  state_d  = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (bus_data_ok) begin
               state_d  = ST_IDLE;
               complete = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (complete) begin
         if (owner_q == OWN_DATA) begin
            data_done_d  = 1'b1;
            data_rdata_d = bus_rdata;
         end else begin
            inst_done_d  = 1'b1;
            inst_rdata_d = bus_rdata;
         end
      end
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width of all ports.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- inst_en  in  1  fetch read request; held until inst_done.
- inst_addr  in  ADDR_WIDTH  fetch word address.
- inst_rdata  out  DATA_WIDTH  fetch read data; valid while inst_done=1.
- inst_done  out  1  one-cycle completion pulse, fetch port.
- data_en  in  1  data request (MEM-stage ram_en); held until data_done.
- data_write_en  in  4  byte enables; 0000 means read.
- data_addr  in  ADDR_WIDTH  data word address (low 2 bits already 00).
- data_write_data  in  DATA_WIDTH  store data, lane-aligned.
- data_rdata  out  DATA_WIDTH  load data; valid while data_done=1.
- data_done  out  1  one-cycle completion pulse, data port.
- stall_req  out  1  pipeline stall request.
- bus_req  out  1  shared-bus request valid.
- bus_we  out  4  shared-bus byte write enables.
- bus_addr  out  ADDR_WIDTH  shared-bus address.
- bus_wdata  out  DATA_WIDTH  shared-bus write data.
- bus_addr_ok  in  1  bus accepted request this cycle.
- bus_data_ok  in  1  bus response/write-ack this cycle.
- bus_rdata  in  DATA_WIDTH  bus read data, valid with bus_data_ok.

Function
REQ-003 FSM states: IDLE, REQ, WAIT; a 1-bit owner register records granted port (DATA/INST).
REQ-004 IDLE: an eligible port is one with en=1 and its done=0 this cycle; data port has fixed priority over fetch; on grant latch addr, byte enables (0000 for fetch), wdata and owner, go to REQ.
REQ-005 REQ: bus_req=1 with latched bus_addr/bus_we/bus_wdata held stable; on bus_addr_ok go to WAIT; if bus_addr_ok and bus_data_ok in the same cycle go directly to IDLE and complete.
REQ-006 WAIT: bus_req=0; on bus_data_ok go to IDLE and complete.
REQ-007 Completion: on next edge, owner's done=1 for exactly one cycle and owner's rdata register loads bus_rdata (write: rdata register loads bus_rdata, ignored by requester).
REQ-008 Minimum latency: request sampled in IDLE at cycle N, bus_req at N+1, addr_ok+data_ok at N+1 gives done at N+2.
REQ-009 At most one bus transaction outstanding; no new grant in REQ or WAIT.
REQ-010 bus_data_ok in IDLE or REQ without addr_ok is ignored (no state change, no done).
REQ-011 stall_req = (data_en & ~data_done) | (inst_en & ~inst_done), combinational.
REQ-012 bus_we, bus_addr, bus_wdata = 0 whenever bus_req=0.
REQ-013 Requester dropping en mid-transaction does not abort it; done still pulses once.

Reset
REQ-014 On rst low, immediately: state IDLE, owner DATA, bus_req 0, bus_we 0, bus_addr 0, bus_wdata 0, inst_done 0, data_done 0, inst_rdata 0, data_rdata 0.
REQ-015 Reset mid-transaction abandons it; late bus_data_ok after reset release is ignored per REQ-010.

Structure
REQ-016 State encodings and owner codes are defined as constants in the shared define header used by core stages.
REQ-017 Single flat module; no sub-modules.

Verification
REQ-018 Fetch read: inst_en=1, addr 0xBFC00000, addr_ok at N+1, data_ok at N+3, rdata 0x3C080001 -> inst_done one cycle at N+4, inst_rdata=0x3C080001.
REQ-019 Simultaneous: data_en (read 0x80001000) and inst_en at N -> data served first, data_done then fetch issued; bus_addr sequence 0x80001000, then fetch address.
REQ-020 Store byte: data_write_en=0100, wdata 0x00AB0000, addr 0x80000004 -> bus_we=0100, bus_wdata=0x00AB0000 until addr_ok; data_done after data_ok.
REQ-021 Back-to-back: addr_ok and data_ok same cycle as bus_req -> done at N+2, no second bus_req for the held en during the done cycle.
REQ-022 rst low while in WAIT -> all outputs 0 asynchronously; bus_data_ok pulse after release -> no done pulse.
REQ-023 stall_req: data_en=1 for 4 cycles until data_done -> stall_req high those cycles except done cycle.
